dff_bank_arbiter: RTL and testbench
===================================

# dff_bank_arbiter

Round-robin arbiter and write sequencer for a single shared WIDTH-bit register built from asynchronous-reset D flip-flops. N requesters compete for write access. The block grants one requester at a time and loads that requester's data into the register. It holds ownership for HOLD cycles, then acknowledges the requester. It sits between the requesting control blocks and the shared flop bank, and is the only writer of that bank.

## Interface
Parameters:
- N, default 4: number of requesters, from 2 to 8.
- WIDTH, default 8: register width in bits.
- HOLD, default 2: number of cycles one grant owns the register, at least 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  N  level request, one bit per requester.
- wdata  in  N*WIDTH  write data; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  out  N  one-hot grant, registered.
- ack  out  N  one-cycle completion pulse, registered.
- q  out  WIDTH  shared register contents.
- owner  out  clog2(N)  index of the current or last granted requester.
- busy  out  1  high while in GRANT.

## Operation
- FSM has two states: IDLE and GRANT.
- IDLE:
  - If any req bit is high, pick the winner i as the first set bit searching upward from rr_ptr, wrapping modulo N.
  - At the next edge: state goes to GRANT, gnt becomes one-hot(i), owner becomes i, busy becomes 1, hold counter loads HOLD-1.
  - If no req bit is high, stay in IDLE with all outputs holding their value, except ack, which is 0.
- GRANT:
  - On the first GRANT edge only, q loads wdata[i].
  - The counter decrements each cycle.
  - When the counter is 0, ack[i] is 1 in that same cycle.
  - At the following edge: gnt goes to 0, busy goes to 0, rr_ptr becomes (i+1) mod N, state returns to IDLE.
- There is always at least one IDLE cycle between grants. A requester that saw ack has deasserted req before IDLE samples again, so it is never double-granted.
- req dropping during GRANT is a protocol violation. The block ignores it, completes the grant and issues ack.
- wdata for the owner needs to be stable only in the first GRANT cycle.
- Simultaneous requests are resolved by rr_ptr priority only; there is no fixed priority.
- Reset asserted at any time, including mid-GRANT, aborts the grant. No ack is issued.
- Reset values: q=0, gnt=0, ack=0, owner=0, busy=0, rr_ptr=0, state IDLE.

## Timing
- req is sampled high at edge k while in IDLE.
- gnt is high from edge k+1 through edge k+1+HOLD.
- q is valid with the new value after edge k+2.
- ack is high in the cycle between edge k+HOLD and edge k+HOLD+1.
- The state is IDLE after edge k+HOLD+1.
- With HOLD=1, ack coincides with the first GRANT cycle.
- Throughput is one write per HOLD+1 cycles under continuous demand.
- Reset assertion acts immediately, with no clock needed. Deassertion takes effect at the next rising clk; the system is responsible for synchronising it.
- gnt and ack are never both nonzero for different indices in the same cycle.

## Structure
- Shared header package dff_arb_pkg holds:
  - state encodings ST_IDLE=1'b0 and ST_GRANT=1'b1;
  - a clog2 helper function;
  - default parameter constants.
- Sub-module dreg is the natural split: a WIDTH-bit D register with enable, q=0 on active-low asynchronous reset. The arbiter instantiates one dreg with en = first GRANT cycle and d = the muxed wdata.
- Round-robin search is a combinational function of req and rr_ptr. No other sub-modules.

## Test plan
- Single request, HOLD=2:
  - Stimulus: req=0001 with wdata[0]=8'hA5.
  - Required: gnt=0001 for 2 cycles; q=A5 after the first grant edge; ack[0] pulses once in the second grant cycle; busy falls afterwards.
- Simultaneous requests:
  - Stimulus: req=0110 from reset, wdata[1]=8'h11, wdata[2]=8'h22.
  - Required: owner=1 first and q=11; then owner=2 and q=22.
- Saturation:
  - Stimulus: req=1111 held, with each requester dropping its req after its ack and re-raising it 2 cycles later.
  - Required: grant order 0,1,2,3,0,1; a grant every 3 cycles.
- Reset mid-operation:
  - Stimulus: assert reset low in the first GRANT cycle of requester 3.
  - Required: q, gnt, ack and busy go to 0 immediately; no ack[3]; the next grant after release goes to requester 0 if it is requesting.
- HOLD=1 build:
  - Stimulus: req=0001 alone.
  - Required: gnt and ack[0] are both high in the same single cycle; q updated after that edge.
- Early drop:
  - Stimulus: req[2] deasserted in the first GRANT cycle.
  - Required: grant still completes; q=wdata[2]; ack[2] is issued.

Source files
------------

// File: rtl/dff_arb_pkg.sv
// dff_arb_pkg: shared definitions for the dff_bank_arbiter slice.
//   - st_e      : arbiter FSM state encoding (IDLE / GRANT)
//   - DEF_*     : default parameter values for the arbiter and its register
//   - clog2()   : ceiling log2, never smaller than 1 so index ports stay legal
package dff_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } st_e;

    localparam int DEF_N     = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_HOLD  = 2;

    // Minimum of 1 so that a 1-entry range (e.g. HOLD=1 counter) still
    // yields a usable 1-bit vector.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dreg.sv
// dreg: WIDTH-bit D register with load enable, cleared by active-low
// asynchronous reset.
//   clk   in  clock
//   reset in  asynchronous active-low reset (q -> 0)
//   en    in  load enable; q takes d on the rising edge when high
//   d     in  next data
//   q     out register contents
module dreg
    import dff_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin arbiter and write sequencer for one shared
// WIDTH-bit register. One requester at a time is granted, its data is loaded
// into the register, ownership is held for HOLD cycles, then it is acked.
//   clk       in  clock, rising edge
//   reset     in  asynchronous active-low reset
//   req       in  [N]        level request per requester
//   wdata     in  [N*WIDTH]  write data, requester i at [i*WIDTH +: WIDTH]
//   gnt       out [N]        registered one-hot grant
//   ack       out [N]        registered one-cycle completion pulse
//   q         out [WIDTH]    shared register contents
//   owner     out [clog2(N)] current or last granted requester
//   busy      out            high while in GRANT
//   state_dbg out            raw FSM state (ST_IDLE / ST_GRANT)
//
// Handshake: a requester raises req and holds it (and its wdata for at least
// the first grant cycle) until it sees its ack bit; it must drop req in the
// cycle after ack so the following IDLE cycle does not grant it again. gnt
// and ack always refer to the same index while both are high.
module dff_bank_arbiter
    import dff_arb_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WIDTH = DEF_WIDTH,
    parameter int HOLD  = DEF_HOLD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        req,
    input  logic [N*WIDTH-1:0]  wdata,
    output logic [N-1:0]        gnt,
    output logic [N-1:0]        ack,
    output logic [WIDTH-1:0]    q,
    output logic [clog2(N)-1:0] owner,
    output logic                busy,
    output logic                state_dbg
);

    localparam int OW = clog2(N);
    localparam int CW = clog2(HOLD);
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD - 1);

    st_e           state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [OW-1:0] rr_ptr, rr_n, owner_n, winner;
    logic [N-1:0]  gnt_n, ack_n, win_oh, own_oh;
    logic          busy_n, any_req, first_cyc;
    logic [WIDTH-1:0] wsel;

    // Round-robin pick: scan downward from rr_ptr+N-1 to rr_ptr so the last
    // hit written is the first set bit searching upward from rr_ptr.
    always_comb begin : rr_search
        int idx;
        any_req = 1'b0;
        winner  = '0;
        idx     = 0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = (int'(rr_ptr) + off) % N;
            if (req[idx]) begin
                any_req = 1'b1;
                winner  = OW'(idx);
            end
        end
    end

    always_comb begin
        win_oh         = '0;
        win_oh[winner] = 1'b1;
        own_oh         = '0;
        own_oh[owner]  = 1'b1;
    end

    // Counter is loaded with HOLD-1 on entry, so cnt==CNT_LOAD only in the
    // first GRANT cycle; that is the one cycle the owner's data is captured.
    assign first_cyc = (state == ST_GRANT) && (cnt == CNT_LOAD);
    assign wsel      = wdata[owner*WIDTH +: WIDTH];
    assign state_dbg = state;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rr_n    = rr_ptr;
        owner_n = owner;
        gnt_n   = gnt;
        busy_n  = busy;
        ack_n   = '0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_n = ST_GRANT;
                    gnt_n   = win_oh;
                    owner_n = winner;
                    busy_n  = 1'b1;
                    cnt_n   = CNT_LOAD;
                    // With a single-cycle hold the ack lands in the first
                    // (and only) GRANT cycle.
                    if (HOLD == 1) begin
                        ack_n = win_oh;
                    end
                end
            end
            ST_GRANT: begin
                if (cnt == '0) begin
                    state_n = ST_IDLE;
                    gnt_n   = '0;
                    busy_n  = 1'b0;
                    rr_n    = (owner == OW'(N - 1)) ? '0 : owner + 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                    // ack is registered, so raise it on the edge into the
                    // cycle where the counter reads 0.
                    if (cnt == CW'(1)) begin
                        ack_n = own_oh;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            rr_ptr <= '0;
            owner  <= '0;
            gnt    <= '0;
            ack    <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rr_ptr <= rr_n;
            owner  <= owner_n;
            gnt    <= gnt_n;
            ack    <= ack_n;
            busy   <= busy_n;
        end
    end

    dreg #(.WIDTH(WIDTH)) u_dreg (
        .clk   (clk),
        .reset (reset),
        .en    (first_cyc),
        .d     (wsel),
        .q     (q)
    );

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter: HOLD=2 instance with an ack
// scoreboard, plus a HOLD=1 instance checked directly.
module tb_dff_bank_arbiter;

    localparam int SBW = 11; // {index[2:0], data[7:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt, ack;
    logic [7:0]  q;
    logic [1:0]  owner;
    logic        busy, state_dbg;

    logic [3:0]  req1;
    logic [31:0] wdata1;
    logic [3:0]  gnt1, ack1;
    logic [7:0]  q1;
    logic [1:0]  owner1;
    logic        busy1, state_dbg1;

    dff_bank_arbiter #(.N(4), .WIDTH(8), .HOLD(2)) u_dut (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata),
        .gnt(gnt), .ack(ack), .q(q), .owner(owner), .busy(busy),
        .state_dbg(state_dbg)
    );

    dff_bank_arbiter #(.N(4), .WIDTH(8), .HOLD(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req1), .wdata(wdata1),
        .gnt(gnt1), .ack(ack1), .q(q1), .owner(owner1), .busy(busy1),
        .state_dbg(state_dbg1)
    );

    // ---------------- scoreboard state ----------------
    logic [SBW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic void push_exp(input int idx, input logic [7:0] d);
        exp_q.push_back({3'(idx), d});
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic set_wd(input int i, input logic [7:0] v);
        wdata[i*8 +: 8] = v;
    endtask

    // Wait (bounded) for ack[idx], then return just after the next edge,
    // which is when a well-behaved requester drops its req.
    task automatic wait_ack(input int idx);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (ack[idx]) seen = 1'b1;
        end
        check($sformatf("wait_ack%0d", idx), 32'(seen), 32'h1);
        tick();
    endtask

    // ---------------- monitor ----------------
    task automatic monitor();
        logic [SBW-1:0] e;
        logic [3:0]     e_oh;
        forever begin
            @(negedge clk);
            if (reset && ack != 4'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'(ack), 32'h0);
                end else begin
                    e    = exp_q.pop_front();
                    e_oh = 4'b0001 << e[SBW-1:8];
                    check("ack_idx",   32'(ack),   32'(e_oh));
                    check("ack_q",     32'(q),     32'(e[7:0]));
                    check("ack_owner", 32'(owner), 32'(e[SBW-1:8]));
                    check("ack_gnt",   32'(gnt),   32'(e_oh));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int   rr_cnt[4];
        int   n_acks, n_g, last_g;
        logic [3:0] acks_now, prev_gnt;

        reset = 1'b0; req = '0; wdata = '0; req1 = '0; wdata1 = '0;
        fork
            monitor();
        join_none

        // Reset values
        tick();
        tick();
        check("rst_q",     32'(q),         32'h0);
        check("rst_gnt",   32'(gnt),       32'h0);
        check("rst_ack",   32'(ack),       32'h0);
        check("rst_owner", 32'(owner),     32'h0);
        check("rst_busy",  32'(busy),      32'h0);
        check("rst_state", 32'(state_dbg), 32'h0);
        reset = 1'b1;

        // Single request, HOLD=2
        req = 4'b0001; set_wd(0, 8'hA5); push_exp(0, 8'hA5);
        tick();
        check("t1_gnt_c1",  32'(gnt),       32'h1);
        check("t1_busy_c1", 32'(busy),      32'h1);
        check("t1_state",   32'(state_dbg), 32'h1);
        check("t1_ack_c1",  32'(ack),       32'h0);
        check("t1_q_c1",    32'(q),         32'h0);
        tick();
        check("t1_gnt_c2",  32'(gnt),       32'h1);
        check("t1_q_c2",    32'(q),         32'hA5);
        check("t1_ack_c2",  32'(ack),       32'h1);
        tick();
        req = 4'b0000;
        check("t1_gnt_end",  32'(gnt),  32'h0);
        check("t1_busy_end", 32'(busy), 32'h0);
        check("t1_ack_end",  32'(ack),  32'h0);
        check("t1_q_hold",   32'(q),    32'hA5);
        tick();
        check("t1_no_regnt", 32'(gnt),  32'h0);

        // Simultaneous requests from reset
        do_reset();
        req = 4'b0110; set_wd(1, 8'h11); set_wd(2, 8'h22);
        push_exp(1, 8'h11); push_exp(2, 8'h22);
        wait_ack(1); req[1] = 1'b0;
        wait_ack(2); req[2] = 1'b0;

        // Saturation: drop after ack, re-raise two cycles later
        do_reset();
        set_wd(0, 8'hA0); set_wd(1, 8'hB1); set_wd(2, 8'hC2); set_wd(3, 8'hD3);
        push_exp(0, 8'hA0); push_exp(1, 8'hB1); push_exp(2, 8'hC2);
        push_exp(3, 8'hD3); push_exp(0, 8'hA0); push_exp(1, 8'hB1);
        req = 4'b1111;
        for (int i = 0; i < 4; i++) rr_cnt[i] = 0;
        n_acks = 0; n_g = 0; last_g = 0; prev_gnt = 4'b0;
        for (int c = 0; c < 60 && n_acks < 6; c++) begin
            @(negedge clk);
            acks_now = ack;
            if (gnt != 4'b0 && prev_gnt == 4'b0) begin
                if (n_g > 0) check("sat_gap", 32'(c - last_g), 32'd3);
                last_g = c;
                n_g++;
            end
            prev_gnt = gnt;
            tick();
            for (int i = 0; i < 4; i++) begin
                if (acks_now[i]) begin
                    n_acks++;
                    req[i]    = 1'b0;
                    rr_cnt[i] = 2;
                end else if (rr_cnt[i] > 0) begin
                    rr_cnt[i]--;
                    if (rr_cnt[i] == 0) req[i] = 1'b1;
                end
            end
            if (n_acks >= 6) req = 4'b0000;
        end
        check("sat_acks", 32'(n_acks), 32'd6);

        // Reset in first GRANT cycle of requester 3 (rr_ptr is 2 here)
        req = 4'b1000;
        tick();
        check("t4_gnt3",   32'(gnt), 32'h8);
        check("t4_q_prev", 32'(q),   32'hB1);
        #2;
        reset = 1'b0;
        #1;
        check("t4_rst_q",    32'(q),    32'h0);
        check("t4_rst_gnt",  32'(gnt),  32'h0);
        check("t4_rst_ack",  32'(ack),  32'h0);
        check("t4_rst_busy", 32'(busy), 32'h0);
        req = 4'b1001;
        tick();
        reset = 1'b1;
        push_exp(0, 8'hA0); push_exp(3, 8'hD3);
        wait_ack(0); req[0] = 1'b0;
        wait_ack(3); req[3] = 1'b0;

        // Early drop of req[2] in its first GRANT cycle (rr_ptr is 0)
        req = 4'b0100; set_wd(2, 8'h5C); push_exp(2, 8'h5C);
        tick();
        req[2] = 1'b0;
        tick();
        set_wd(2, 8'hFF);
        wait_ack(2);
        check("t6_q",   32'(q),   32'h5C);
        check("t6_gnt", 32'(gnt), 32'h0);

        // HOLD=1 instance
        req1 = 4'b0001; wdata1[7:0] = 8'h3C;
        tick();
        check("h1_gnt",  32'(gnt1),  32'h1);
        check("h1_ack",  32'(ack1),  32'h1);
        check("h1_busy", 32'(busy1), 32'h1);
        check("h1_q_c1", 32'(q1),    32'h0);
        req1 = 4'b0000;
        tick();
        check("h1_gnt_end",  32'(gnt1),  32'h0);
        check("h1_ack_end",  32'(ack1),  32'h0);
        check("h1_q",        32'(q1),    32'h3C);
        check("h1_busy_end", 32'(busy1), 32'h0);

        tick();
        check("sb_empty", 32'(exp_q.size()), 32'h0);

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
